// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter sharing one sound-board channel among game-event requesters.
// Optional build macro SOUND_ARB_PREEMPT_EN lets a higher-priority request cut the current track.
module sound_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          RST_CYCLES   = 4,
  parameter int          PLAY_CYCLES  = 25000000,
  parameter logic [5:0]  SILENT_TRACK = 6'd0
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [6*NUM_REQ-1:0]   req_track,
  input  logic                   mute,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   snd_reset,
  output logic [5:0]             selection
);

  localparam int MAX_CYC = (RST_CYCLES > PLAY_CYCLES) ? RST_CYCLES : PLAY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(PLAY_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_TRIGGER, ST_PLAY} state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_pending;
  logic [CNT_W-1:0]     r_counter;
  logic [IDX_W-1:0]     r_cur_idx;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_busy;
  logic                 r_snd_reset;
  logic [5:0]           r_selection;

  state_t               w_state_next;
  logic [NUM_REQ-1:0]   w_pending_next;
  logic [CNT_W-1:0]     w_counter_next;
  logic [IDX_W-1:0]     w_cur_idx_next;
  logic [NUM_REQ-1:0]   w_grant_next;
  logic                 w_busy_next;
  logic                 w_snd_reset_next;
  logic [5:0]           w_selection_next;
  logic                 w_start;

  logic [IDX_W-1:0]     w_winner;
  logic                 w_any;
  logic                 w_preempt;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [5:0]           w_tracks [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_track
      assign w_tracks[gi] = req_track[6*gi +: 6];
    end
  endgenerate

  // Highest set index of the registered pending vector wins; raw req is never arbitrated.
  always_comb begin
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_pending[i]) w_winner = IDX_W'(i);
    end
  end

  assign w_any    = |r_pending;
  assign w_win_oh = NUM_REQ'(1) << w_winner;

`ifdef SOUND_ARB_PREEMPT_EN
  assign w_preempt = w_any && (w_winner > r_cur_idx);
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_pending_next   = r_pending | req;
    w_counter_next   = r_counter;
    w_cur_idx_next   = r_cur_idx;
    w_grant_next     = '0;
    w_snd_reset_next = r_snd_reset;
    w_selection_next = r_selection;
    w_start          = 1'b0;

    if (mute) begin
      w_state_next     = ST_IDLE;
      w_pending_next   = '0;
      w_counter_next   = '0;
      w_snd_reset_next = 1'b0;
      w_selection_next = SILENT_TRACK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_selection_next = SILENT_TRACK;
          w_snd_reset_next = 1'b0;
          w_start          = w_any;
        end
        ST_TRIGGER: begin
          if (w_preempt) begin
            w_start = 1'b1;
          end else if (r_counter == '0) begin
            w_state_next     = ST_PLAY;
            w_snd_reset_next = 1'b0;
            w_counter_next   = PLAY_LOAD;
          end else begin
            w_counter_next = r_counter - CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (w_preempt) begin
            w_start = 1'b1;
          end else if (r_counter == '0) begin
            w_state_next     = ST_IDLE;
            w_selection_next = SILENT_TRACK;
          end else begin
            w_counter_next = r_counter - CNT_W'(1);
          end
        end
        default: w_state_next = ST_IDLE;
      endcase

      // A req on the grant edge re-sets the bit being cleared, so the track replays later.
      if (w_start) begin
        w_state_next     = ST_TRIGGER;
        w_cur_idx_next   = w_winner;
        w_selection_next = w_tracks[w_winner];
        w_snd_reset_next = 1'b1;
        w_grant_next     = w_win_oh;
        w_counter_next   = RST_LOAD;
        w_pending_next   = (r_pending & ~w_win_oh) | req;
      end
    end

    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_counter   <= '0;
      r_cur_idx   <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_snd_reset <= 1'b0;
      r_selection <= SILENT_TRACK;
    end else begin
      r_state     <= w_state_next;
      r_pending   <= w_pending_next;
      r_counter   <= w_counter_next;
      r_cur_idx   <= w_cur_idx_next;
      r_grant     <= w_grant_next;
      r_busy      <= w_busy_next;
      r_snd_reset <= w_snd_reset_next;
      r_selection <= w_selection_next;
    end
  end

  assign grant     = r_grant;
  assign busy      = r_busy;
  assign snd_reset = r_snd_reset;
  assign selection = r_selection;

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter: directed scenarios plus random traffic against an elapsed-time model.
// Follows SOUND_ARB_PREEMPT_EN the same way the design does.
module tb_sound_arbiter;

  localparam int         NR  = 4;
  localparam int         RC  = 2;
  localparam int         PC  = 10;
  localparam logic [5:0] SIL = 6'd0;
`ifdef SOUND_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [NR-1:0]     req;
  logic [6*NR-1:0]   req_track;
  logic              mute;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              snd_reset;
  logic [5:0]        selection;

  always #5 PCLK = ~PCLK;

  sound_arbiter #(
    .NUM_REQ(NR), .RST_CYCLES(RC), .PLAY_CYCLES(PC), .SILENT_TRACK(SIL)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_track(req_track), .mute(mute),
    .grant(grant), .busy(busy), .snd_reset(snd_reset), .selection(selection)
  );

  // Model: a track is described by the number of edges elapsed since its grant.
  bit            m_play = 1'b0;
  int            m_el   = 0;
  int            m_cur  = 0;
  bit [NR-1:0]   m_pend = '0;
  logic [NR-1:0] e_grant = '0;
  logic          e_busy = 1'b0;
  logic          e_snd  = 1'b0;
  logic [5:0]    e_sel  = SIL;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [NR-1:0] r, input logic m, input logic p);
    int win;
    bit start;
    win   = -1;
    start = 1'b0;
    for (int i = 0; i < NR; i++) if (m_pend[i]) win = i;
    e_grant = '0;
    if (p) begin
      m_play = 1'b0; m_el = 0; m_cur = 0; m_pend = '0; e_sel = SIL;
    end else if (m) begin
      m_play = 1'b0; m_pend = '0; e_sel = SIL;
    end else begin
      if (m_play) begin
        if (PREEMPT && win > m_cur) start = 1'b1;
        else if (m_el + 1 == RC + PC) begin m_play = 1'b0; e_sel = SIL; end
        else m_el++;
      end else if (win >= 0) begin
        start = 1'b1;
      end
      if (start) begin
        m_cur = win; m_el = 0; m_play = 1'b1;
        e_sel = req_track[6*win +: 6];
        e_grant[win] = 1'b1;
        m_pend[win] = 1'b0;
      end
      m_pend |= r;
    end
    e_busy = m_play;
    e_snd  = m_play && (m_el < RC);
  endtask

  task automatic step(input logic [NR-1:0] r, input logic m, input logic p);
    req = r; mute = m; PRESET = p;
    @(posedge PCLK);
    model_edge(r, m, p);
    #1;
    chk("grant", grant, e_grant);
    chk("busy", busy, e_busy);
    chk("snd_reset", snd_reset, e_snd);
    chk("selection", selection, e_sel);
    req = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0);
  endtask

  initial begin
    int g;
    req = '0; mute = 1'b0; PRESET = 1'b1;
    req_track = {6'd9, 6'd7, 6'd5, 6'd3};

    step('0, 1'b0, 1'b1);
    chk("reset_sel", selection, SIL);
    chk("reset_busy", busy, 1'b0);
    idle(2);

    // single request: grant two edges after the pulse, 12 cycles of track 5
    step(4'b0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("single_grant", grant, 4'b0010);
    chk("single_sel", selection, 6'd5);
    idle(11);
    chk("single_sel_last", selection, 6'd5);
    idle(1);
    chk("single_done_sel", selection, SIL);
    chk("single_done_busy", busy, 1'b0);
    idle(2);

    // simultaneous requests: 3 before 1, one silent IDLE cycle between
    step(4'b1010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("simul_first", grant, 4'b1000);
    chk("simul_first_sel", selection, 6'd9);
    idle(12);
    chk("simul_gap_sel", selection, SIL);
    chk("simul_gap_grant", grant, 4'b0000);
    step('0, 1'b0, 1'b0);
    chk("simul_second", grant, 4'b0010);
    chk("simul_second_sel", selection, 6'd5);
    idle(15);

    // coalesce: three re-requests during play give one replay
    step(4'b0100, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    idle(3);
    step(4'b0100, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    g = 0;
    for (int k = 0; k < 40; k++) begin
      step('0, 1'b0, 1'b0);
      if (grant[2]) g++;
    end
    chk("replay_count", g, 1);

    // mute mid-play with a pending request
    step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    idle(4);
    step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("mute_sel", selection, SIL);
    chk("mute_busy", busy, 1'b0);
    step('0, 1'b1, 1'b0);
    g = 0;
    for (int k = 0; k < 20; k++) begin
      step('0, 1'b0, 1'b0);
      if (grant != '0) g++;
    end
    chk("mute_no_grant", g, 0);

    // high-priority request arriving mid-play
    step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    idle(6);
    step(4'b1000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("preempt_grant", grant, PREEMPT ? 4'b1000 : 4'b0000);
    idle(30);

    // reset during TRIGGER, then a normal request
    step(4'b0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    chk("rst_trig_busy", busy, 1'b0);
    chk("rst_trig_snd", snd_reset, 1'b0);
    chk("rst_trig_sel", selection, SIL);
    step(4'b0100, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("post_rst_grant", grant, 4'b0100);
    chk("post_rst_sel", selection, 6'd7);
    idle(14);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      logic [NR-1:0] r;
      logic m, p;
      if ($urandom_range(0, 19) == 0) req_track = $urandom;
      r = ($urandom_range(0, 5) == 0) ? NR'($urandom) : '0;
      m = ($urandom_range(0, 60) == 0);
      p = ($urandom_range(0, 250) == 0);
      step(r, m, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
